// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: triggered dual-channel ADC capture into a circular RAM with a trigger-aligned read view.
//   Optional feature macro AUTO_TRIG_EN adds auto_timeout (in, 24b) and auto_fired (out): forced trigger after a WAIT timeout.
//   Ports: clk, rst_n (async active-low); adc_a/adc_b samples; arm pulse; trig_src/trig_rising/trig_level trigger setup;
//          pre_len pre-trigger count; decim strobe divider; mem_addr -> mem_data (1-clk registered read);
//          busy/triggered/done status.
module adc_capture_buffer #(
  parameter int AW = 12,
  parameter int DW = 8,
  parameter int DEC_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DW-1:0] adc_a,
  input  logic [DW-1:0] adc_b,
  input  logic arm,
  input  logic trig_src,
  input  logic trig_rising,
  input  logic [DW-1:0] trig_level,
  input  logic [AW-1:0] pre_len,
  input  logic [DEC_W-1:0] decim,
  input  logic [AW-1:0] mem_addr,
`ifdef AUTO_TRIG_EN
  input  logic [23:0] auto_timeout,
  output logic auto_fired,
`endif
  output logic [2*DW-1:0] mem_data,
  output logic busy,
  output logic triggered,
  output logic done
);
  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  state_t state, state_nx;
  logic [2*DW-1:0] ram [2**AW];
  logic [AW-1:0] wr_ptr, trig_addr, pre_q;
  logic [AW:0] cnt, cnt_nx, post_len;
  logic [DEC_W-1:0] dec_cnt;
  logic [DW-1:0] prev, cur;
  logic prev_vld, stb, wr, edge_hit, forced, trig;
  assign busy = state == PRE || state == WAIT || state == POST;
  assign done = state == DONE;
  assign stb = busy && dec_cnt == decim;
  // arm pre-empts the strobe in its own cycle
  assign wr = stb && !arm;
  assign cur = trig_src ? adc_b : adc_a;
  assign edge_hit = prev_vld && (trig_rising ? prev < trig_level && cur >= trig_level
                                             : prev > trig_level && cur <= trig_level);
  assign trig = wr && state == WAIT && (edge_hit || forced);
  assign cnt_nx = cnt + 1'b1;
  // post-trigger samples (trigger sample included) needed to fill the RAM
  assign post_len = DEPTH - {1'b0, pre_q};
  always_comb begin
    state_nx = state;
    if (arm) state_nx = |pre_len ? PRE : WAIT;
    else if (wr && state == PRE) state_nx = cnt_nx == {1'b0, pre_q} ? WAIT : PRE;
    else if (trig) state_nx = post_len == (AW+1)'(1) ? DONE : POST;
    else if (wr && state == POST && cnt_nx == post_len) state_nx = DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      trig_addr <= '0;
      pre_q <= '0;
      cnt <= '0;
      dec_cnt <= '0;
      prev <= '0;
      prev_vld <= 1'b0;
      triggered <= 1'b0;
      mem_data <= '0;
    end else begin
      // oldest pre-trigger sample sits pre_q words behind the trigger word
      mem_data <= ram[trig_addr - pre_q + mem_addr];
      if (arm) begin
        pre_q <= pre_len;
        cnt <= '0;
        dec_cnt <= '0;
        prev_vld <= 1'b0;
        triggered <= 1'b0;
      end else if (busy) begin
        dec_cnt <= stb ? '0 : dec_cnt + 1'b1;
        if (wr) begin
          wr_ptr <= wr_ptr + 1'b1;
          prev <= cur;
          prev_vld <= 1'b1;
          cnt <= trig ? (AW+1)'(1) : cnt_nx;
        end
        if (trig) begin
          trig_addr <= wr_ptr;
          triggered <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (wr) ram[wr_ptr] <= {adc_a, adc_b};
`ifdef AUTO_TRIG_EN
  logic [23:0] tmr;
  logic pend;
  // once the timeout is hit, the request is held until the next strobe takes it
  assign forced = state == WAIT && (pend || (|auto_timeout && tmr == auto_timeout));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tmr <= '0;
      pend <= 1'b0;
      auto_fired <= 1'b0;
    end else if (arm) begin
      tmr <= '0;
      pend <= 1'b0;
      auto_fired <= 1'b0;
    end else begin
      tmr <= state_nx == WAIT && state != WAIT ? '0 : state == WAIT ? tmr + 1'b1 : tmr;
      pend <= state_nx == WAIT && forced;
      auto_fired <= auto_fired | (trig && forced);
    end
`else
  assign forced = 1'b0;
`endif
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: randomized scoreboard bench for adc_capture_buffer (AW=4) against a sample-list reference model.
module tb_adc_capture_buffer;
  localparam int AW = 4, DW = 8, D = 16, LEN = 1000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] adc_a = '0, adc_b = '0, trig_level = '0;
  logic arm = 1'b0, trig_src = 1'b0, trig_rising = 1'b0;
  logic [AW-1:0] pre_len = '0, mem_addr = '0, rd_a = '0;
  logic [15:0] decim = '0;
  logic [2*DW-1:0] mem_data;
  logic busy, triggered, done;
`ifdef AUTO_TRIG_EN
  logic [23:0] auto_timeout = '0;
  logic auto_fired;
`endif
  logic [7:0] wa [LEN];
  logic [7:0] wb [LEN];
  logic [15:0] exp_q [$];
  logic rd_iss = 1'b0, rd_d = 1'b0;
  int checks = 0, errors = 0;

  adc_capture_buffer #(.AW(AW), .DW(DW), .DEC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .adc_a(adc_a), .adc_b(adc_b), .arm(arm),
    .trig_src(trig_src), .trig_rising(trig_rising), .trig_level(trig_level),
    .pre_len(pre_len), .decim(decim), .mem_addr(mem_addr),
`ifdef AUTO_TRIG_EN
    .auto_timeout(auto_timeout), .auto_fired(auto_fired),
`endif
    .mem_data(mem_data), .busy(busy), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(posedge clk) begin
    rd_d <= rd_iss;
    rd_a <= mem_addr;
  end

  always @(negedge clk)
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected actual=%0h required=none", mem_data);
      end else chk($sformatf("rd[%0d]", rd_a), mem_data, exp_q.pop_front());
    end

  task automatic run_capture(input string nm, input int pre, input int d, input bit src, input bit ris,
                             input int lvl, input int tmo, input bit stop_at_trig);
    int ns, t, ta, ts, cf, e, p, c, trg_cyc, done_cyc;
    int sa [$];
    int sb [$];
    bit af;
    ns = LEN / (d + 1) - 1;
    for (int j = 0; j < ns; j++) begin
      sa.push_back(int'(wa[(j + 1) * (d + 1)]));
      sb.push_back(int'(wb[(j + 1) * (d + 1)]));
    end
    t = -1;
    for (int j = (pre > 1 ? pre : 1); j < ns && t < 0; j++) begin
      p = src ? sb[j - 1] : sa[j - 1];
      c = src ? sb[j] : sa[j];
      if (ris ? (p < lvl && c >= lvl) : (p > lvl && c <= lvl)) t = j;
    end
    ta = -1;
    e = pre * (d + 1);
    if (tmo > 0)
      for (int j = pre; j < ns && ta < 0; j++)
        if ((j + 1) * (d + 1) >= e + 1 + tmo) ta = j;
    af = ta >= 0 && (t < 0 || ta <= t);
    if (af) t = ta;
    ts = t >= 0 ? (t + 1) * (d + 1) : -1;
    cf = (t >= 0 && t + D - pre - 1 < ns && !stop_at_trig) ? (t + D - pre) * (d + 1) : -1;
    @(negedge clk);
    arm = 1'b1;
    pre_len = AW'(pre);
    decim = 16'(d);
    trig_src = src;
    trig_rising = ris;
    trig_level = 8'(lvl);
`ifdef AUTO_TRIG_EN
    auto_timeout = 24'(tmo);
`endif
    adc_a = wa[0];
    adc_b = wb[0];
    @(negedge clk);
    arm = 1'b0;
    chk({nm, ".busy_arm"}, busy, 1);
    chk({nm, ".trig_arm"}, triggered, 0);
    chk({nm, ".done_arm"}, done, 0);
    trg_cyc = -1;
    done_cyc = -1;
    for (int k = 1; k < LEN; k++) begin
      adc_a = wa[k];
      adc_b = wb[k];
      @(negedge clk);
      if (triggered && trg_cyc < 0) trg_cyc = k;
      if (done && done_cyc < 0) done_cyc = k;
      if (done || (stop_at_trig && triggered)) break;
    end
    chk({nm, ".trig_cycle"}, trg_cyc, ts);
    if (!stop_at_trig) chk({nm, ".done_cycle"}, done_cyc, cf);
    if (ts < 0) chk({nm, ".busy_notrig"}, busy, 1);
`ifdef AUTO_TRIG_EN
    if (cf >= 0) chk({nm, ".auto_fired"}, auto_fired, af);
`endif
    if (cf >= 0) begin
      for (int k = 0; k < D; k++) begin
        mem_addr = AW'(k);
        rd_iss = 1'b1;
        exp_q.push_back({8'(sa[t - pre + k]), 8'(sb[t - pre + k])});
        @(negedge clk);
      end
      rd_iss = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic fill_walk();
    int va, vb;
    va = int'($urandom_range(0, 255));
    vb = int'($urandom_range(0, 255));
    for (int k = 0; k < LEN; k++) begin
      wa[k] = 8'(va);
      wb[k] = 8'(vb);
      va += int'($urandom_range(0, 16)) - 8;
      vb += int'($urandom_range(0, 16)) - 8;
      va = va < 0 ? 0 : va > 255 ? 255 : va;
      vb = vb < 0 ? 0 : vb > 255 ? 255 : vb;
    end
  endtask

  task automatic fill_ramp(input int off);
    for (int k = 0; k < LEN; k++) begin
      wa[k] = 8'(k + off);
      wb[k] = 8'($urandom);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.triggered", triggered, 0);
    chk("rst.done", done, 0);
    chk("rst.mem_data", mem_data, 0);
    rst_n = 1'b1;
    fill_ramp(-1);
    run_capture("basic", 4, 0, 0, 1, 10, 0, 0);
    for (int k = 0; k < LEN; k++) begin
      wa[k] = 8'($urandom);
      wb[k] = k < 201 ? 8'(201 - k) : 8'd0;
    end
    run_capture("fall_b", 6, 0, 1, 0, 150, 0, 0);
    fill_ramp(0);
    run_capture("decim3", 4, 3, 0, 1, 40, 0, 0);
    run_capture("pre0", 0, 0, 0, 1, 30, 0, 0);
    run_capture("pre15", 15, 0, 0, 1, 20, 0, 0);
    for (int k = 0; k < LEN; k++) begin
      wa[k] = 8'd200;
      wb[k] = 8'($urandom);
    end
    run_capture("no_cross", 3, 0, 0, 1, 100, 0, 0);
    fill_ramp(0);
    run_capture("abort", 4, 0, 0, 1, 10, 0, 1);
    fill_walk();
    run_capture("rearm", 5, 1, 0, 1, 128, 0, 0);
    fill_ramp(0);
    run_capture("abort2", 4, 0, 0, 1, 10, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.busy", busy, 0);
    chk("async_rst.triggered", triggered, 0);
    chk("async_rst.done", done, 0);
    chk("async_rst.mem_data", mem_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      fill_walk();
      run_capture($sformatf("rnd%0d", i), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(60, 190)), 0, 0);
    end
`ifdef AUTO_TRIG_EN
    for (int k = 0; k < LEN; k++) begin
      wa[k] = 8'd77;
      wb[k] = 8'd77;
    end
    run_capture("auto", 0, 0, 0, 1, 100, 50, 0);
`endif
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
